// File: rtl/conv_window_pipe.sv
// conv_window_pipe: streaming KxK signed convolution with per-window magnitude/clamp/shift post-processing
module conv_window_pipe #(
  parameter int KSIZE = 5,
  parameter int PIX_W = 8,
  parameter int COEF_W = 8,
  parameter int SUM_W = PIX_W + COEF_W + $clog2(KSIZE * KSIZE)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [KSIZE*KSIZE*PIX_W-1:0]    window,
  input  logic [KSIZE*KSIZE*COEF_W-1:0]   kernel,
  input  logic [1:0]                      mode,
  input  logic [3:0]                      shift,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PIX_W-1:0]                result,
  output logic signed [SUM_W-1:0]         raw_sum,
  output logic                            neg,
  output logic                            sat
);
  localparam int N = KSIZE * KSIZE;
  localparam int L = $clog2(N);
  localparam int MAX_PIX = (1 << PIX_W) - 1;
  logic en;
  logic [L:0] vld;
  logic signed [SUM_W-1:0] tree [L+1][N];
  logic signed [SUM_W-1:0] nxt [L][N];
  logic [1:0] md [L+1];
  logic [3:0] sh [L+1];
  logic signed [SUM_W-1:0] s, a, t, v;
  logic lo, hi;
  assign en = out_ready | ~out_valid;
  assign in_ready = en;
  for (genvar l = 0; l < L; l++) begin : g_lvl
    for (genvar j = 0; j < N; j++) begin : g_node
      if (2 * j + 1 < ((N - 1) >> l) + 1) begin : g_pair
        assign nxt[l][j] = tree[l][2*j] + tree[l][2*j+1];
      end else if (2 * j < ((N - 1) >> l) + 1) begin : g_tail
        assign nxt[l][j] = tree[l][2*j];
      end else begin : g_zero
        assign nxt[l][j] = '0;
      end
    end
  end
  always_comb begin
    s = tree[L][0];
    a = s < 0 ? -s : s;
    t = s >>> sh[L];
    v = md[L] == 2'd0 ? a : md[L] == 2'd2 ? t : s;
    lo = v < 0;
    hi = v > MAX_PIX;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      out_valid <= 1'b0;
      result <= '0;
      raw_sum <= '0;
      neg <= 1'b0;
      sat <= 1'b0;
    end else if (en) begin
      vld <= {vld[L-1:0], in_valid};
      out_valid <= vld[L];
      for (int j = 0; j < N; j++)
        tree[0][j] <= $signed(kernel[j*COEF_W +: COEF_W]) * $signed({1'b0, window[j*PIX_W +: PIX_W]});
      md[0] <= mode;
      sh[0] <= shift;
      for (int l = 0; l < L; l++) begin
        for (int j = 0; j < N; j++)
          tree[l+1][j] <= nxt[l][j];
        md[l+1] <= md[l];
        sh[l+1] <= sh[l];
      end
      result <= lo ? '0 : hi ? PIX_W'(MAX_PIX) : v[PIX_W-1:0];
      raw_sum <= s;
      neg <= s < 0;
      sat <= lo | hi;
    end
  end
endmodule

// File: tb/tb_conv_window_pipe.sv
// tb_conv_window_pipe: scoreboard bench for conv_window_pipe with a plain-arithmetic reference model
module tb_conv_window_pipe;
  localparam int N = 25;
  localparam int D = 7;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, neg, sat;
  logic [N*8-1:0] window, kernel;
  logic [1:0] mode;
  logic [3:0] shift;
  logic [7:0] result;
  logic [20:0] raw_sum;
  typedef struct {
    int res;
    int raw;
    int ng;
    int st;
    bit lat;
    int acc;
  } exp_t;
  exp_t sb[$];
  int px[N];
  int cf[N];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int st0 = 1 << 30;
  bit rnd = 1'b0;
  bit held = 1'b0;
  int h_res, h_raw, h_neg, h_sat;
  conv_window_pipe #(.KSIZE(5), .PIX_W(8), .COEF_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .window(window), .kernel(kernel), .mode(mode), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .raw_sum(raw_sum), .neg(neg), .sat(sat)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    out_ready = rnd ? ($urandom % 4 != 0) : !(cyc >= st0 && cyc < st0 + 5);
  end
  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask
  function automatic exp_t model(input int md, input int sh);
    exp_t e;
    int s = 0;
    int v;
    for (int i = 0; i < N; i++) s += px[i] * cf[i];
    if (md == 0) v = s < 0 ? -s : s;
    else if (md == 2) v = s >= 0 ? s / (1 << sh) : -((-s + (1 << sh) - 1) / (1 << sh));
    else v = s;
    e.raw = s;
    e.ng = s < 0 ? 1 : 0;
    e.st = (v < 0 || v > 255) ? 1 : 0;
    e.res = v < 0 ? 0 : v > 255 ? 255 : v;
    e.lat = 1'b0;
    e.acc = 0;
    return e;
  endfunction
  task automatic send(input int md, input int sh, input bit lat);
    exp_t e;
    bit done = 1'b0;
    for (int i = 0; i < N; i++) begin
      window[i*8 +: 8] = px[i][7:0];
      kernel[i*8 +: 8] = cf[i][7:0];
    end
    mode = md[1:0];
    shift = sh[3:0];
    in_valid = 1'b1;
    for (int w = 0; w < 200 && !done; w++) begin
      @(negedge clk);
      if (in_ready) begin
        e = model(md, sh);
        e.lat = lat;
        e.acc = cyc;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask
  task automatic fill(input int p, input int c);
    for (int i = 0; i < N; i++) begin
      px[i] = p;
      cf[i] = c;
    end
  endtask
  task automatic ident(input int p);
    fill(0, 0);
    px[12] = p;
    cf[12] = 1;
  endtask
  task automatic drain;
    for (int w = 0; w < 400 && sb.size() > 0; w++) @(negedge clk);
    if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("in_ready", int'(in_ready), (out_valid && !out_ready) ? 0 : 1);
      if (held) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_result", int'(result), h_res);
        chk("stall_raw", int'($signed(raw_sum)), h_raw);
        chk("stall_neg", int'(neg), h_neg);
        chk("stall_sat", int'(sat), h_sat);
      end
      held = out_valid && !out_ready;
      h_res = int'(result);
      h_raw = int'($signed(raw_sum));
      h_neg = int'(neg);
      h_sat = int'(sat);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          e = sb.pop_front();
          chk("result", int'(result), e.res);
          chk("raw_sum", int'($signed(raw_sum)), e.raw);
          chk("neg", int'(neg), e.ng);
          chk("sat", int'(sat), e.st);
          if (e.lat) chk("latency", cyc - e.acc, D);
        end
      end
    end else held = 1'b0;
  end
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    window = '0;
    kernel = '0;
    mode = '0;
    shift = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_raw", int'($signed(raw_sum)), 0);
    chk("rst_neg", int'(neg), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    ident(100);
    send(0, 0, 1'b1);
    fill(255, 1);
    send(0, 0, 1'b1);
    fill(10, -1);
    send(0, 0, 1'b1);
    send(1, 0, 1'b1);
    fill(40, 1);
    send(2, 2, 1'b1);
    send(2, 1, 1'b1);
    fill(10, -1);
    for (int i = 0; i < 6; i++) send(i % 2, 0, 1'b1);
    drain();
    st0 = cyc + 10;
    for (int i = 1; i <= 12; i++) begin
      ident(i);
      send(0, 0, 1'b0);
    end
    drain();
    st0 = 1 << 30;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 1; i <= 4; i++) begin
      ident(200 + i);
      send(0, 0, 1'b0);
    end
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_result", int'(result), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    ident(77);
    send(1, 0, 1'b1);
    drain();
    rnd = 1'b1;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < N; i++) begin
        px[i] = int'($urandom_range(0, 255));
        cf[i] = int'($urandom_range(0, 255)) - 128;
      end
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 1'b0);
      if ($urandom % 3 == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rnd = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
